// File: rtl/mmss_timer_if.sv
// Bundle of control inputs and display/status outputs for the mm:ss timer.
// The timer connects through the slave modport; whoever drives the controls
// and watches the display uses the master modport.
interface mmss_timer_if;
    logic       run;
    logic       down;
    logic       load;
    logic [6:0] preset_min;
    logic [5:0] preset_sec;
    logic [6:0] min_hi;
    logic [6:0] min_lo;
    logic [6:0] sec_hi;
    logic [6:0] sec_lo;
    logic       tick;
    logic       wrap;
    logic       expired;

    modport slave (
        input  run, down, load, preset_min, preset_sec,
        output min_hi, min_lo, sec_hi, sec_lo, tick, wrap, expired
    );

    modport master (
        output run, down, load, preset_min, preset_sec,
        input  min_hi, min_lo, sec_hi, sec_lo, tick, wrap, expired
    );
endinterface

// File: rtl/mmss_timer.sv
// Minutes:seconds up/down timer with built-in prescaler, preset load,
// wrap/expiry flags and four 7-segment digit outputs.
// Time is kept as four BCD digits so the display decode needs no division.
module mmss_timer #(
    parameter int TICK_DIV = 50_000_000,
    parameter int MIN_MAX  = 59
) (
    input  logic        clk,
    input  logic        reset,
    mmss_timer_if.slave bus
);

    localparam int              PC_W      = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [PC_W-1:0] PC_LAST   = PC_W'(TICK_DIV - 1);
    localparam logic [PC_W-1:0] PC_ZERO   = {PC_W{1'b0}};
    localparam logic [PC_W-1:0] PC_ONE    = PC_W'(1);
    localparam logic [6:0]      MIN_MAX_V = 7'(MIN_MAX);

    // Segment pattern {g,f,e,d,c,b,a}, active-high; non-BCD codes blank.
    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h3F;
            4'd1:    s = 7'h06;
            4'd2:    s = 7'h5B;
            4'd3:    s = 7'h4F;
            4'd4:    s = 7'h66;
            4'd5:    s = 7'h6D;
            4'd6:    s = 7'h7D;
            4'd7:    s = 7'h07;
            4'd8:    s = 7'h7F;
            4'd9:    s = 7'h6F;
            default: s = 7'h00;
        endcase
        return s;
    endfunction

    // Binary 0..99 to {tens, units} BCD by repeated subtraction of ten.
    function automatic logic [7:0] bin2bcd(input logic [6:0] v);
        logic [6:0] r;
        logic [3:0] t;
        r = v;
        t = 4'd0;
        for (int i = 0; i < 9; i++) begin
            if (r >= 7'd10) begin
                r = r - 7'd10;
                t = t + 4'd1;
            end else begin
                r = r;
            end
        end
        return {t, r[3:0]};
    endfunction

    logic [3:0]      min_t_r, min_u_r, sec_t_r, sec_u_r;
    logic [PC_W-1:0] pc_r;
    logic            tick_r, wrap_r;

    logic [3:0] nxt_min_t_s, nxt_min_u_s, nxt_sec_t_s, nxt_sec_u_s;
    logic       wrap_s;
    logic [6:0] min_bin_s;
    logic [6:0] pmin_s;
    logic [5:0] psec_s;
    logic       zero_s;
    logic       blocked_s;

    assign min_bin_s = ({3'b000, min_t_r} * 7'd10) + {3'b000, min_u_r};
    assign zero_s    = (min_t_r == 4'd0) && (min_u_r == 4'd0) &&
                       (sec_t_r == 4'd0) && (sec_u_r == 4'd0);
    // A down-count parked at 00:00 freezes the prescaler instead of wrapping.
    assign blocked_s = bus.down && zero_s;
    assign pmin_s    = (bus.preset_min > MIN_MAX_V) ? MIN_MAX_V : bus.preset_min;
    assign psec_s    = (bus.preset_sec > 6'd59) ? 6'd59 : bus.preset_sec;

    // Next displayed value for one count step in the current direction.
    always_comb begin
        nxt_min_t_s = min_t_r;
        nxt_min_u_s = min_u_r;
        nxt_sec_t_s = sec_t_r;
        nxt_sec_u_s = sec_u_r;
        wrap_s      = 1'b0;
        if (bus.down) begin
            if (sec_u_r != 4'd0) begin
                nxt_sec_u_s = sec_u_r - 4'd1;
            end else begin
                nxt_sec_u_s = 4'd9;
                if (sec_t_r != 4'd0) begin
                    nxt_sec_t_s = sec_t_r - 4'd1;
                end else begin
                    nxt_sec_t_s = 4'd5;
                    if (min_u_r != 4'd0) begin
                        nxt_min_u_s = min_u_r - 4'd1;
                    end else if (min_t_r != 4'd0) begin
                        nxt_min_u_s = 4'd9;
                        nxt_min_t_s = min_t_r - 4'd1;
                    end else begin
                        nxt_min_u_s = min_u_r;
                    end
                end
            end
        end else begin
            if (sec_u_r != 4'd9) begin
                nxt_sec_u_s = sec_u_r + 4'd1;
            end else begin
                nxt_sec_u_s = 4'd0;
                if (sec_t_r != 4'd5) begin
                    nxt_sec_t_s = sec_t_r + 4'd1;
                end else begin
                    nxt_sec_t_s = 4'd0;
                    if (min_bin_s >= MIN_MAX_V) begin
                        nxt_min_t_s = 4'd0;
                        nxt_min_u_s = 4'd0;
                        wrap_s      = 1'b1;
                    end else if (min_u_r != 4'd9) begin
                        nxt_min_u_s = min_u_r + 4'd1;
                    end else begin
                        nxt_min_u_s = 4'd0;
                        nxt_min_t_s = min_t_r + 4'd1;
                    end
                end
            end
        end
    end

    // Digit, prescaler and pulse registers: reset > load > step > hold.
    always_ff @(posedge clk) begin
        if (!reset) begin
            min_t_r <= 4'd0;
            min_u_r <= 4'd0;
            sec_t_r <= 4'd0;
            sec_u_r <= 4'd0;
            pc_r    <= PC_ZERO;
            tick_r  <= 1'b0;
            wrap_r  <= 1'b0;
        end else if (bus.load) begin
            {min_t_r, min_u_r} <= bin2bcd(pmin_s);
            {sec_t_r, sec_u_r} <= bin2bcd({1'b0, psec_s});
            pc_r    <= PC_ZERO;
            tick_r  <= 1'b0;
            wrap_r  <= 1'b0;
        end else if (blocked_s) begin
            pc_r    <= PC_ZERO;
            tick_r  <= 1'b0;
            wrap_r  <= 1'b0;
        end else if (bus.run) begin
            if (pc_r == PC_LAST) begin
                pc_r    <= PC_ZERO;
                min_t_r <= nxt_min_t_s;
                min_u_r <= nxt_min_u_s;
                sec_t_r <= nxt_sec_t_s;
                sec_u_r <= nxt_sec_u_s;
                tick_r  <= 1'b1;
                wrap_r  <= wrap_s;
            end else begin
                pc_r    <= pc_r + PC_ONE;
                tick_r  <= 1'b0;
                wrap_r  <= 1'b0;
            end
        end else begin
            // Paused: prescaler phase is kept so resuming continues the period.
            tick_r <= 1'b0;
            wrap_r <= 1'b0;
        end
    end

    assign bus.min_hi  = seg7(min_t_r);
    assign bus.min_lo  = seg7(min_u_r);
    assign bus.sec_hi  = seg7(sec_t_r);
    assign bus.sec_lo  = seg7(sec_u_r);
    assign bus.tick    = tick_r;
    assign bus.wrap    = wrap_r;
    assign bus.expired = bus.down && zero_s;

endmodule
